// File: rtl/ctrl_seq.sv
// Microcoded-style control sequencer: a six-state one-hot ring counter (T1..T6) plus
// a halt latch; the 30-bit control word is decoded combinationally from T-state, opcode and flags.
module ctrl_seq (
    input  logic        clk,
    input  logic        clr,
    input  logic [7:0]  ins,
    input  logic        am,
    input  logic        az,
    input  logic        xm,
    input  logic        xz,
    output logic [29:0] con,
    output logic [5:0]  t,
    output logic        hlt
);

    localparam int LP  = 29;
    localparam int CP  = 28;
    localparam int EP  = 27;
    localparam int LS  = 26;
    localparam int CS  = 25;
    localparam int ES  = 24;
    localparam int LM  = 23;
    localparam int WE  = 22;
    localparam int CE  = 21;
    localparam int LD  = 20;
    localparam int ED  = 19;
    localparam int LI  = 18;
    localparam int EI  = 17;
    localparam int LN  = 16;
    localparam int EN  = 15;
    localparam int LA  = 14;
    localparam int EA  = 13;
    localparam int S3  = 12;
    localparam int S2  = 11;
    localparam int S1  = 10;
    localparam int S0  = 9;
    localparam int M   = 8;
    localparam int CI  = 7;
    localparam int EU  = 6;
    localparam int LB  = 5;
    localparam int LX  = 4;
    localparam int INX = 3;
    localparam int DEX = 2;
    localparam int EX  = 1;
    localparam int LO  = 0;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_STA  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_JAM  = 4'h6;
    localparam logic [3:0] OP_JAZ  = 4'h7;
    localparam logic [3:0] OP_JXM  = 4'h8;
    localparam logic [3:0] OP_JXZ  = 4'h9;
    localparam logic [3:0] OP_IN   = 4'hA;
    localparam logic [3:0] OP_OUT  = 4'hB;
    localparam logic [3:0] OP_INX  = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    logic [3:0] op;
    logic [5:0] t_next;
    logic       hlt_next;
    logic       t_ok;
    logic       unused_ins;

    assign op         = ins[7:4];
    assign unused_ins = ^ins[3:0];

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
    assign t_ok = (t != 6'b0) && ((t & (t - 6'd1)) == 6'b0);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            t   <= T1;
            hlt <= 1'b0;
        end else begin
            t   <= t_next;
            hlt <= hlt_next;
        end
    end

    // The if-form keeps an unknown opcode from setting hlt (and thus freezing t) in simulation.
    always_comb begin
        t_next   = T1;
        hlt_next = hlt;
        if (!t_ok) begin
            t_next = T1;
        end else if (hlt) begin
            t_next = t;
        end else begin
            t_next = {t[4:0], t[5]};
            if ((t == T4) && (op == OP_HLT)) begin
                hlt_next = 1'b1;
            end
        end
    end

    always_comb begin
        con = 30'b0;
        if (!hlt) begin
            case (t)
                T1: begin
                    con[EP] = 1'b1;
                    con[LM] = 1'b1;
                end
                T2: con[CP] = 1'b1;
                T3: begin
                    con[CE] = 1'b1;
                    con[LI] = 1'b1;
                end
                T4: begin
                    case (op)
                        OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
                            con[EI] = 1'b1;
                            con[LM] = 1'b1;
                        end
                        OP_JMP: begin
                            con[EI] = 1'b1;
                            con[LP] = 1'b1;
                        end
                        OP_JAM: begin
                            con[EI] = am;
                            con[LP] = am;
                        end
                        OP_JAZ: begin
                            con[EI] = az;
                            con[LP] = az;
                        end
                        OP_JXM: begin
                            con[EI] = xm;
                            con[LP] = xm;
                        end
                        OP_JXZ: begin
                            con[EI] = xz;
                            con[LP] = xz;
                        end
                        OP_IN: begin
                            con[EN] = 1'b1;
                            con[LA] = 1'b1;
                        end
                        OP_OUT: begin
                            con[EA] = 1'b1;
                            con[LO] = 1'b1;
                        end
                        OP_INX: con[INX] = 1'b1;
                        OP_CALL: begin
                            con[EP] = 1'b1;
                            con[LS] = 1'b1;
                        end
                        OP_RET: begin
                            con[ES] = 1'b1;
                            con[LP] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (op)
                        OP_LDA: begin
                            con[CE] = 1'b1;
                            con[LA] = 1'b1;
                        end
                        OP_STA: begin
                            con[EA] = 1'b1;
                            con[LD] = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            con[CE] = 1'b1;
                            con[LB] = 1'b1;
                        end
                        OP_CALL: begin
                            con[EI] = 1'b1;
                            con[LP] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    case (op)
                        OP_STA: con[WE] = 1'b1;
                        // ALU function select: 1001 is A plus B, 0110 with carry-in is A minus B.
                        OP_ADD: begin
                            con[EU] = 1'b1;
                            con[LA] = 1'b1;
                            con[S3] = 1'b1;
                            con[S0] = 1'b1;
                        end
                        OP_SUB: begin
                            con[EU] = 1'b1;
                            con[LA] = 1'b1;
                            con[S2] = 1'b1;
                            con[S1] = 1'b1;
                            con[CI] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: system clock; all state changes on the rising edge.
REQ-002 The block SHALL have port clr, input, 1 bit: reset, asynchronous, active-high.
REQ-003 The block SHALL have port ins, input, 8 bits: instruction-register control field; opcode = ins[7:4], ins[3:0] ignored.
REQ-004 The block SHALL have ports am, az, xm, xz, inputs, 1 bit each: accumulator negative/zero and pointer negative/zero flags.
REQ-005 The block SHALL have port con, output, 30 bits: control word. Bit map: [29:27] lp,cp,ep; [26:24] ls,cs,es; [23] lm; [22:21] we,ce; [20:19] ld,ed; [18:17] li,ei; [16:15] ln,en; [14:13] la,ea; [12:6] s3,s2,s1,s0,m,ci,eu; [5] lb; [4:1] lx,inx,dex,ex; [0] lo.
REQ-006 The block SHALL have port t, output, 6 bits: one-hot T-state, t[0]=T1 .. t[5]=T6.
REQ-007 The block SHALL have port hlt, output, 1 bit: halted flag.

Function
REQ-008 The ring counter SHALL advance T1->T2->..->T6->T1, one state per clk edge, while hlt=0.
REQ-009 Every instruction SHALL take exactly 6 T-states; T-states with no listed signals SHALL drive con=0.
REQ-010 con SHALL be combinational from t, ins and flags; control signals not listed for a state SHALL be 0.
REQ-011 Fetch: T1 ep,lm; T2 cp; T3 ce,li (all opcodes).
REQ-012 0 NOP: no execute signals.
REQ-013 1 LDA: T4 ei,lm; T5 ce,la.
REQ-014 2 STA: T4 ei,lm; T5 ea,ld; T6 we.
REQ-015 3 ADD: T4 ei,lm; T5 ce,lb; T6 eu,la with s3..s0=1001, m=0, ci=0.
REQ-016 4 SUB: as ADD, except T6 uses s3..s0=0110, m=0, ci=1.
REQ-017 5 JMP: T4 ei,lp.
REQ-018 6 JAM / 7 JAZ / 8 JXM / 9 JXZ: T4 ei,lp only if am / az / xm / xz respectively =1 during T4, else none.
REQ-019 A IN: T4 en,la.
REQ-020 B OUT: T4 ea,lo.
REQ-021 C INX: T4 inx.
REQ-022 D CALL: T4 ep,ls; T5 ei,lp.
REQ-023 E RET: T4 es,lp.
REQ-024 F HLT: hlt SHALL set on the clk edge ending T4.
REQ-025 While hlt=1: t SHALL freeze at T5 and con SHALL be 0.
REQ-026 Only clr SHALL clear hlt.
REQ-027 Flags SHALL be evaluated only in T4; flag changes in other states SHALL NOT affect con.
REQ-028 Undriven/X ins bits SHALL NOT corrupt t; t SHALL always be exactly one-hot.
REQ-029 If t is ever found non-one-hot, it SHALL recover to T1 on the next edge.

Reset
REQ-030 clr=1 SHALL immediately force t=000001 (T1) and hlt=0, independent of clk.
REQ-031 During reset, con SHALL equal the T1 word (ep,lm only).
REQ-032 clr asserted mid-instruction SHALL abort it; the first edge after release SHALL move to T2.
REQ-033 clr SHALL override HLT and any simultaneous clk edge.

Verification
REQ-034 clr pulse, then ins=8'h10 for 6 clocks -> con: T1 ep,lm; T2 cp; T3 ce,li; T4 ei,lm; T5 ce,la; T6 0; back to T1.
REQ-035 ins=8'h60 with am=0 -> T4 con=0; repeat with am=1 -> T4 con has only ei,lp set.
REQ-036 ins=8'h30 -> T6 con = eu,la with con[12:6]=1001001; ins=8'h40 -> con[12:6]=0110011.
REQ-037 ins=8'hF0 -> hlt=1 after T4 edge; t stays 010000 for 20 clocks with con=0; clr -> t=000001, hlt=0.
REQ-038 clr asserted asynchronously during T5 of STA -> t=000001 within the same cycle; we never asserted.
REQ-039 ins=8'hD0 then 8'hE0 -> CALL T4 ep,ls; T5 ei,lp; RET T4 es,lp.
